// File: rtl/mfp_ahb_arbiter_if.sv
// Bus bundle between the two AHB-Lite masters, the arbiter and the slave fabric.
// Signal names match the AHB-Lite naming used by the m14k system.
interface mfp_ahb_arbiter_if;
  // master 0 (MIPS core)
  logic        m0_HBUSREQ;
  logic        m0_HGRANT;
  logic [31:0] m0_HADDR;
  logic [1:0]  m0_HTRANS;
  logic        m0_HWRITE;
  logic [2:0]  m0_HSIZE;
  logic [2:0]  m0_HBURST;
  logic        m0_HMASTLOCK;
  logic [31:0] m0_HWDATA;
  // master 1 (accelerometer sample DMA)
  logic        m1_HBUSREQ;
  logic        m1_HGRANT;
  logic [31:0] m1_HADDR;
  logic [1:0]  m1_HTRANS;
  logic        m1_HWRITE;
  logic [2:0]  m1_HSIZE;
  logic [2:0]  m1_HBURST;
  logic        m1_HMASTLOCK;
  logic [31:0] m1_HWDATA;
  // slave side
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HMASTER;
  logic        HMASTER_D;

  // arbiter view: serves the masters and drives the slave port
  modport slave (
    input  m0_HBUSREQ, m0_HADDR, m0_HTRANS, m0_HWRITE, m0_HSIZE, m0_HBURST,
           m0_HMASTLOCK, m0_HWDATA,
    input  m1_HBUSREQ, m1_HADDR, m1_HTRANS, m1_HWRITE, m1_HSIZE, m1_HBURST,
           m1_HMASTLOCK, m1_HWDATA,
    output m0_HGRANT, m1_HGRANT,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA,
    input  HREADY,
    output HMASTER, HMASTER_D
  );

  // environment view: the masters and the slave fabric around the arbiter
  modport master (
    output m0_HBUSREQ, m0_HADDR, m0_HTRANS, m0_HWRITE, m0_HSIZE, m0_HBURST,
           m0_HMASTLOCK, m0_HWDATA,
    output m1_HBUSREQ, m1_HADDR, m1_HTRANS, m1_HWRITE, m1_HSIZE, m1_HBURST,
           m1_HMASTLOCK, m1_HWDATA,
    input  m0_HGRANT, m1_HGRANT,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA,
    output HREADY,
    input  HMASTER, HMASTER_D
  );
endinterface

// File: rtl/mfp_ahb_arbiter.sv
// Two-master AHB-Lite arbiter and bus multiplexer (m14k core + sample DMA).
// Owns grant sequencing, address/data-phase ownership and hold-count fairness.
module mfp_ahb_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              HCLK,
  input  logic              SI_Reset,
  mfp_ahb_arbiter_if.slave  bus
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BU_SINGLE = 3'b000;
  localparam logic [7:0] MAX_HOLD_W = 8'(MAX_HOLD);

  typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} state_t;

  // 8-bit saturating increment for the hold counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // 5-bit saturating increment for the burst beat counter
  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'h1F) ? v : v + 5'd1;
  endfunction

  // beats in a fixed-length burst; 0 for SINGLE and undefined-length INCR
  function automatic logic [4:0] burst_len(input logic [2:0] b);
    logic [4:0] len;
    case (b[2:1])
      2'b01:   len = 5'd4;
      2'b10:   len = 5'd8;
      2'b11:   len = 5'd16;
      default: len = 5'd0;
    endcase
    return len;
  endfunction

  state_t      state;
  logic [1:0]  grant_q;
  logic        hmaster_d;
  logic [7:0]  hold_cnt;
  logic [4:0]  beat_cnt;

  logic        sel_m1;
  logic [1:0]  own_trans;
  logic [2:0]  own_burst;
  logic        own_lock;
  logic        own_req;
  logic        oth_req;
  logic        xfer;
  logic        last_beat;
  logic        busy;
  logic [7:0]  hold_seen;
  logic        do_switch;
  logic        do_park;
  logic        change;

  // Address-phase mux; reset forces M0 onto the slave port immediately.
  assign sel_m1 = ~SI_Reset & (state == OWN_M1);

  // slave-side address phase from the address owner, write data from the data-phase owner
  always_comb begin
    bus.HADDR     = sel_m1 ? bus.m1_HADDR     : bus.m0_HADDR;
    bus.HTRANS    = sel_m1 ? bus.m1_HTRANS    : bus.m0_HTRANS;
    bus.HWRITE    = sel_m1 ? bus.m1_HWRITE    : bus.m0_HWRITE;
    bus.HSIZE     = sel_m1 ? bus.m1_HSIZE     : bus.m0_HSIZE;
    bus.HBURST    = sel_m1 ? bus.m1_HBURST    : bus.m0_HBURST;
    bus.HMASTLOCK = sel_m1 ? bus.m1_HMASTLOCK : bus.m0_HMASTLOCK;
    bus.HWDATA    = (~SI_Reset & hmaster_d) ? bus.m1_HWDATA : bus.m0_HWDATA;
  end

  assign bus.m0_HGRANT = grant_q[0];
  assign bus.m1_HGRANT = grant_q[1];
  assign bus.HMASTER   = (state == OWN_M1);
  assign bus.HMASTER_D = hmaster_d;

  // owner status and the arbitration decision for the coming HREADY edge
  always_comb begin
    own_trans = (state == OWN_M1) ? bus.m1_HTRANS    : bus.m0_HTRANS;
    own_burst = (state == OWN_M1) ? bus.m1_HBURST    : bus.m0_HBURST;
    own_lock  = (state == OWN_M1) ? bus.m1_HMASTLOCK : bus.m0_HMASTLOCK;
    own_req   = (state == OWN_M1) ? bus.m1_HBUSREQ   : bus.m0_HBUSREQ;
    oth_req   = (state == OWN_M1) ? bus.m0_HBUSREQ   : bus.m1_HBUSREQ;

    xfer = (own_trans == TR_NONSEQ) || (own_trans == TR_SEQ);

    // The final SEQ of a fixed-length burst frees the bus, so the grant can
    // move on the edge that completes that address phase.
    last_beat = (own_trans == TR_SEQ) && (burst_len(own_burst) != 5'd0) &&
                ((beat_cnt + 5'd1) == burst_len(own_burst));

    busy = (own_lock && (own_trans != TR_IDLE)) ||
           (own_trans == TR_BUSY) ||
           ((own_trans == TR_SEQ) && !last_beat) ||
           ((own_trans == TR_NONSEQ) && (own_burst != BU_SINGLE));

    // hold count including the transfer completing on this edge, so the
    // owner gets exactly MAX_HOLD transfers before yielding
    hold_seen = (xfer && oth_req) ? sat_inc8(hold_cnt) : hold_cnt;

    do_switch = !busy && oth_req && (!own_req || (hold_seen >= MAX_HOLD_W));
    do_park   = !busy && !bus.m0_HBUSREQ && !bus.m1_HBUSREQ && (state == OWN_M1);
    change    = do_switch || do_park;
  end

  // ownership FSM with registered grants, data-phase owner and counters
  always_ff @(posedge HCLK) begin
    if (SI_Reset) begin
      state     <= OWN_M0;
      grant_q   <= 2'b01;
      hmaster_d <= 1'b0;
      hold_cnt  <= 8'd0;
      beat_cnt  <= 5'd0;
    end else if (bus.HREADY) begin
      hmaster_d <= (state == OWN_M1);
      if (change) begin
        state    <= (state == OWN_M1) ? OWN_M0 : OWN_M1;
        grant_q  <= (state == OWN_M1) ? 2'b01 : 2'b10;
        hold_cnt <= 8'd0;
        beat_cnt <= 5'd0;
      end else begin
        hold_cnt <= oth_req ? hold_seen : 8'd0;
        if (own_trans == TR_NONSEQ)
          beat_cnt <= 5'd1;
        else if (own_trans == TR_SEQ)
          beat_cnt <= sat_inc5(beat_cnt);
      end
    end
  end

endmodule

// File: tb/tb_mfp_ahb_arbiter.sv
// Directed bench for mfp_ahb_arbiter with MAX_HOLD = 2.
module tb_mfp_ahb_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [31:0] A0 = 32'hA0A0_A0A0;
  localparam logic [31:0] B1 = 32'hB1B1_B1B1;

  mfp_ahb_arbiter_if bus();

  mfp_ahb_arbiter #(.MAX_HOLD(2)) dut (
    .HCLK     (clk),
    .SI_Reset (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int n, input logic req, input logic [1:0] trans,
                         input logic [2:0] burst, input logic lock);
    if (n == 0) begin
      bus.m0_HBUSREQ = req; bus.m0_HTRANS = trans;
      bus.m0_HBURST = burst; bus.m0_HMASTLOCK = lock;
    end else begin
      bus.m1_HBUSREQ = req; bus.m1_HTRANS = trans;
      bus.m1_HBURST = burst; bus.m1_HMASTLOCK = lock;
    end
  endtask

  task automatic check_own(input string tag, input logic hm, input logic hd);
    check_eq({tag, "_hmaster"},   32'(bus.HMASTER),   32'(hm));
    check_eq({tag, "_hmaster_d"}, 32'(bus.HMASTER_D), 32'(hd));
    check_eq({tag, "_grant0"},    32'(bus.m0_HGRANT), 32'(!hm));
    check_eq({tag, "_grant1"},    32'(bus.m1_HGRANT), 32'(hm));
  endtask

  initial begin
    logic exp_hm [6];
    logic exp_hd [6];
    exp_hm = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_hd = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    bus.HREADY = 1'b1;
    bus.m0_HADDR = 32'h1000_0000; bus.m1_HADDR = 32'h2000_0000;
    bus.m0_HWRITE = 1'b1;         bus.m1_HWRITE = 1'b1;
    bus.m0_HSIZE = 3'b010;        bus.m1_HSIZE = 3'b010;
    bus.m0_HWDATA = A0;           bus.m1_HWDATA = B1;
    drive_m(0, 1'b0, 2'b00, 3'b000, 1'b0);
    drive_m(1, 1'b0, 2'b01, 3'b000, 1'b0);

    // reset state
    tick();
    check_own("reset", 1'b0, 1'b0);
    check_eq("reset_hold", 32'(dut.hold_cnt), 32'd0);
    rst = 1'b0;
    bus.m0_HTRANS = 2'b10;
    #1;
    check_eq("reset_htrans_m0", 32'(bus.HTRANS), 32'(2'b10));
    check_eq("reset_haddr_m0", bus.HADDR, 32'h1000_0000);
    bus.m0_HTRANS = 2'b00;

    // M1 alone requests, then drops: grant then park
    drive_m(1, 1'b1, 2'b00, 3'b000, 1'b0);
    tick();
    check_own("m1_req", 1'b1, 1'b0);
    check_eq("m1_haddr", bus.HADDR, 32'h2000_0000);
    drive_m(1, 1'b0, 2'b00, 3'b000, 1'b0);
    tick();
    check_own("park", 1'b0, 1'b1);

    // contention with NONSEQ singles: alternate every two transfers
    drive_m(0, 1'b1, 2'b10, 3'b000, 1'b0);
    drive_m(1, 1'b1, 2'b10, 3'b000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_own($sformatf("alt%0d", i), exp_hm[i], exp_hd[i]);
      check_eq($sformatf("alt%0d_hwdata", i), bus.HWDATA, exp_hd[i] ? B1 : A0);
    end

    // hand back to M0 (M1 idle, not requesting)
    drive_m(0, 1'b1, 2'b00, 3'b000, 1'b0);
    drive_m(1, 1'b0, 2'b00, 3'b000, 1'b0);
    tick();
    check_eq("back_m0", 32'(bus.HMASTER), 32'd0);

    // INCR4 burst from M0 with M1 requesting: held until the last SEQ completes
    drive_m(1, 1'b1, 2'b00, 3'b000, 1'b0);
    drive_m(0, 1'b1, 2'b10, 3'b011, 1'b0);
    tick();
    check_eq("burst_b1", 32'(bus.HMASTER), 32'd0);
    drive_m(0, 1'b1, 2'b11, 3'b011, 1'b0);
    tick();
    check_eq("burst_b2", 32'(bus.HMASTER), 32'd0);
    tick();
    check_eq("burst_b3", 32'(bus.HMASTER), 32'd0);
    tick();
    check_eq("burst_b4", 32'(bus.HMASTER), 32'd1);

    // locked M1 singles with M0 requesting: no switch until IDLE and unlocked
    drive_m(0, 1'b1, 2'b00, 3'b000, 1'b0);
    drive_m(1, 1'b1, 2'b10, 3'b000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("lock%0d", i), 32'(bus.HMASTER), 32'd1);
    end
    check_eq("lock_hold", 32'(dut.hold_cnt), 32'd3);
    drive_m(1, 1'b1, 2'b00, 3'b000, 1'b0);
    tick();
    check_eq("unlock_switch", 32'(bus.HMASTER), 32'd0);

    // handover with three wait states on M0's final data phase
    drive_m(0, 1'b0, 2'b10, 3'b000, 1'b0);
    drive_m(1, 1'b1, 2'b00, 3'b000, 1'b0);
    tick();
    check_own("ho_switch", 1'b1, 1'b0);
    drive_m(0, 1'b0, 2'b00, 3'b000, 1'b0);
    drive_m(1, 1'b1, 2'b10, 3'b000, 1'b0);
    bus.HREADY = 1'b0;
    #1;
    check_eq("ho_wdata_first", bus.HWDATA, A0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_own($sformatf("ho_wait%0d", i), 1'b1, 1'b0);
      check_eq($sformatf("ho_wait%0d_hwdata", i), bus.HWDATA, A0);
    end
    bus.HREADY = 1'b1;
    tick();
    check_own("ho_done", 1'b1, 1'b1);
    check_eq("ho_hwdata_m1", bus.HWDATA, B1);

    // reset while M1 owns mid-burst with HREADY low
    drive_m(0, 1'b1, 2'b00, 3'b000, 1'b0);
    drive_m(1, 1'b1, 2'b10, 3'b011, 1'b0);
    tick();
    check_own("pre_rst", 1'b1, 1'b1);
    check_eq("pre_rst_hold", 32'(dut.hold_cnt), 32'd1);
    drive_m(1, 1'b1, 2'b11, 3'b011, 1'b0);
    bus.HREADY = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rst_htrans_m0", 32'(bus.HTRANS), 32'(2'b00));
    tick();
    check_own("mid_rst", 1'b0, 1'b0);
    check_eq("mid_rst_hold", 32'(dut.hold_cnt), 32'd0);
    rst = 1'b0;
    bus.HREADY = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
